// File: rtl/hex_entry_if.sv
// Connection bundle for the hex entry stage: the five raw board pushbuttons
// going in, and the live buffer, cursor and committed value coming out.
interface hex_entry_if;
    logic        btn_l;
    logic        btn_r;
    logic        btn_u;
    logic        btn_d;
    logic        btn_c;
    logic [31:0] data;
    logic [2:0]  cursor;
    logic [7:0]  cursor_mask;
    logic [31:0] commit_data;
    logic        commit;

    // The board side (or a bench) drives the buttons and watches the outputs.
    modport master (
        output btn_l, btn_r, btn_u, btn_d, btn_c,
        input  data, cursor, cursor_mask, commit_data, commit
    );

    // The entry stage itself reads the buttons and drives the outputs.
    modport slave (
        input  btn_l, btn_r, btn_u, btn_d, btn_c,
        output data, cursor, cursor_mask, commit_data, commit
    );
endinterface

// File: rtl/hex_entry.sv
// Hexadecimal entry stage feeding the 8-digit seven-segment driver.
// Each pushbutton is synchronised, debounced in both directions and turned
// into a single press pulse. Presses edit a 32-bit buffer one nibble at a
// time under a cursor; the centre button commits the buffer downstream.
module hex_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic       clk,
    input logic       rst,
    hex_entry_if.slave bus
);

    localparam int NUM_BTN = 5;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Button bit positions inside the packed vectors below.
    localparam int B_R = 0;
    localparam int B_L = 1;
    localparam int B_D = 2;
    localparam int B_U = 3;
    localparam int B_C = 4;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_COMMIT,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] stable_q;
    logic [NUM_BTN-1:0] press;
    logic [CNT_W-1:0]   count [NUM_BTN];

    action_t     action;
    logic [31:0] data_r;
    logic [2:0]  cursor_r;
    logic [31:0] commit_data_r;
    logic        commit_r;
    logic [4:0]  nib_base;
    logic [3:0]  nib;

    assign raw = {bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r};

    // Two-flop synchroniser bringing the asynchronous buttons into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the clean level only follows the synchronised level after it
    // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == stable[i]) begin
                    count[i] <= '0;
                end else if (count[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    count[i]  <= '0;
                end else begin
                    count[i] <= count[i] + CNT_ONE;
                end
            end
        end
    end

    // Delayed copy of the clean levels used to find debounced rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable;
        end
    end

    assign press = stable & ~stable_q;

    // Pick at most one action per cycle; lower-priority presses are dropped.
    always_comb begin
        action = ACT_NONE;
        if (press[B_C]) begin
            action = ACT_COMMIT;
        end else if (press[B_U]) begin
            action = ACT_UP;
        end else if (press[B_D]) begin
            action = ACT_DOWN;
        end else if (press[B_L]) begin
            action = ACT_LEFT;
        end else if (press[B_R]) begin
            action = ACT_RIGHT;
        end
    end

    assign nib_base = {cursor_r, 2'b00};
    assign nib      = data_r[nib_base +: 4];

    // Apply the selected edit; nibble arithmetic wraps without carry/borrow
    // and the commit strobe lasts exactly the cycle after the capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r        <= '0;
            cursor_r      <= '0;
            commit_data_r <= '0;
            commit_r      <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            case (action)
                ACT_COMMIT: begin
                    commit_data_r <= data_r;
                    commit_r      <= 1'b1;
                end
                ACT_UP:    data_r[nib_base +: 4] <= nib + 4'd1;
                ACT_DOWN:  data_r[nib_base +: 4] <= nib - 4'd1;
                ACT_LEFT:  cursor_r <= cursor_r + 3'd1;
                ACT_RIGHT: cursor_r <= cursor_r - 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.data        = data_r;
    assign bus.cursor      = cursor_r;
    assign bus.cursor_mask = 8'd1 << cursor_r;
    assign bus.commit_data = commit_data_r;
    assign bus.commit      = commit_r;

endmodule
